// File: rtl/decoder_pkg.sv
// Shared widths, skid occupancy states and the one-hot decode helper.
// Pure declarations: no logic, no latency.
// Imported by the decoder RTL and its bench.
package decoder_pkg;

    localparam int DEC_IN_W      = 3;
    localparam int DEC_OUT_W     = 1 << DEC_IN_W;
    // Widest code the helper accepts; callers truncate the result to their OUT_W.
    localparam int DEC_MAX_IN_W  = 8;
    localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_IN_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_st_e;

    // A disabled decode yields the all-zero word.
    function automatic logic [DEC_MAX_OUT_W-1:0] decode_onehot(
        input logic [DEC_MAX_IN_W-1:0] code,
        input logic                    en
    );
        decode_onehot       = '0;
        decode_onehot[code] = en;
    endfunction

endpackage

// File: rtl/decoder_skid.sv
// Two-entry valid/ready skid buffer, strict FIFO order.
// Latency: 1 cycle from push to out_valid.
// Backpressure: in_ready is registered state only (low when full or in reset).
module decoder_skid
    import decoder_pkg::*;
#(
    parameter int W = DEC_OUT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    skid_st_e     state, state_nxt;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push;
    logic         pop;

    assign in_ready  = (state != ST_TWO) && !rst;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            state  <= state_nxt;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        state_nxt = state;
        head_d    = head_q;
        tail_d    = tail_q;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    head_d    = in_data;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                // Simultaneous push and pop replaces the head in place.
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    tail_d    = in_data;
                    state_nxt = ST_TWO;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    head_d    = tail_q;
                    state_nxt = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

endmodule

// File: rtl/decoder_pipe.sv
// Registered binary-to-one-hot decoder behind a 2-entry skid; optional per-code stats (DECODER_STATS_EN).
// Latency: 1 cycle push to out_valid; 1 word/cycle with out_ready held high.
// Backpressure: in_ready drops only when both skid entries are full; never combinational on out_ready.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int IN_W = DEC_IN_W,
`ifdef DECODER_STATS_EN
    parameter int CNT_W = 16,
`endif
    localparam int OUT_W = 1 << IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
`ifdef DECODER_STATS_EN
    input  logic [IN_W-1:0]  stat_sel,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_cnt,
`endif
    input  logic             out_ready
);

    logic [OUT_W-1:0] dec_word;

    assign dec_word = OUT_W'(decode_onehot(DEC_MAX_IN_W'(in), en));

    decoder_skid #(
        .W (OUT_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (dec_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

`ifdef DECODER_STATS_EN
    logic             push;
    logic [CNT_W-1:0] cnt [OUT_W];

    assign push     = in_valid && in_ready;
    assign stat_cnt = cnt[stat_sel];

    // Clear has priority over a coincident counted push.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int k = 0; k < OUT_W; k++) begin
                cnt[k] <= '0;
            end
        end else if (push && en && (cnt[in] != '1)) begin
            cnt[in] <= cnt[in] + 1'b1;
        end
    end
`endif

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Registered 3-to-8 one-hot decoder with valid/ready handshakes on both sides: the inverse of the priority encoder. It accepts binary codes from an upstream stage, decodes each to a one-hot word, and buffers up to two results in a skid buffer so a stalled consumer never drops data. It sits between code-producing logic (encoder output, register index) and one-hot consumers (select lines, LED banks).

## Interface
- `IN_W`, default 3: code width; output width is `OUT_W = 1 << IN_W`.
- `CNT_W`, default 16: statistics counter width (only with `DECODER_STATS_EN`).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in` in `IN_W`: binary code.
- `en` in 1: decode enable, sampled with `in`.
- `in_valid` in 1: `in`/`en` valid.
- `in_ready` out 1: buffer can accept.
- `out` out `OUT_W`: one-hot result (buffer head).
- `out_valid` out 1: `out` valid.
- `out_ready` in 1: consumer accepts.
- `stat_sel` in `IN_W`: counter select (`DECODER_STATS_EN` only).
- `stat_clr` in 1: clear all counters (`DECODER_STATS_EN` only).
- `stat_cnt` out `CNT_W`: count for `stat_sel` (`DECODER_STATS_EN` only).

## Operation
- Push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- Decoded word = `en ? (1 << in) : 0`. `en` is captured at push, so `en=0` yields an all-zero word. This is the decode of the encoder's "no input" case.
- Buffer: 2 entries, head/tail, occupancy FSM.
  - EMPTY: push goes to ONE.
  - ONE: push only goes to TWO; pop only goes to EMPTY; push and pop together stay in ONE (head replaced by the new word).
  - TWO: pop goes to ONE. Push is impossible.
- `in_ready = (state != TWO) && !rst`. `out_valid = (state != EMPTY)`.
- Order is strict FIFO. No entry is ever dropped or duplicated.
- Code values are always legal; all `IN_W` bits are used. No error path.

## Timing
- Reset values: state EMPTY, `out_valid=0`, `out=0`, `in_ready=0` while `rst` is high and 1 on the first cycle after. `stat_cnt` counters are 0.
- Latency is 1 cycle: a push at edge N gives `out_valid=1` with the decoded word after edge N.
- Throughput is 1 word/cycle when `out_ready` is held high.
- `out` holds stable while `out_valid && !out_ready`.
- `in_ready` depends only on state (registered), never combinationally on `out_ready`.
- Reset mid-operation: buffered entries are discarded at the reset edge and state returns to EMPTY. A handshake asserted in the same cycle as `rst` is ignored.

## Configuration
- `DECODER_STATS_EN` defined:
  - Adds `OUT_W` saturating counters of `CNT_W` bits, one per code value.
  - Counter `k` increments on every push with `in==k` and `en=1`. It saturates at all-ones.
  - `stat_clr` zeroes all counters at the next edge. If `stat_clr` and a push occur together, the clear wins (the count ends at 0).
  - `stat_cnt` is combinational from `stat_sel`.
- Not defined: the counters and the `stat_sel`, `stat_clr`, `stat_cnt` ports do not exist. Datapath behaviour is identical.

## Structure
- Shared package `decoder_pkg`:
  - `IN_W`/`OUT_W` defaults.
  - Occupancy state enum (`ST_EMPTY`, `ST_ONE`, `ST_TWO`).
  - One-hot decode function used by both the RTL and the bench scoreboard.
- Sub-module `decoder_skid`: parameterized 2-entry valid/ready buffer carrying `OUT_W` bits. The top contains the decode logic, instantiates the buffer, and holds the optional stats.

## Test plan
- Codes 0..7 pushed back-to-back with `en=1` and `out_ready=1` -> `out` = 0x01, 0x02, 0x04, … 0x80 on consecutive cycles, each 1 cycle after its push.
- `out_ready=0`, push 5 then 6 -> `in_ready` drops after the second push, `out=0x20` held. Release `out_ready` -> 0x20 then 0x40, and `in_ready` returns to 1.
- State ONE with push 3 and pop in the same cycle -> still one entry, `out=0x08` next cycle, no loss.
- Push code 4 with `en=0` -> `out=0x00`, `out_valid=1`; with `DECODER_STATS_EN`, counter 4 is unchanged.
- Two entries buffered, `rst` pulsed 1 cycle -> `out_valid=0` and `out=0` after that edge, `in_ready=1` on the next cycle, and no stale word appears.
- `DECODER_STATS_EN`, `CNT_W=2`: push code 2 five times -> `stat_cnt`=3 (saturated). Then assert `stat_clr` together with a code-2 push -> 0.
